// File: rtl/phase_freq_est_pkg.sv
// Purpose : shared constants, FSM state and accumulator type for the phase-to-frequency estimator.
// Latency : n/a (declarations only).
// Backpres: n/a.
package phase_freq_pkg;

  localparam int WIDTH_DEF  = 16;     // phase/frequency word width, Q3.13 radians
  localparam int LOG2_N_DEF = 4;      // default averaging block of 16 differences
  localparam int PI_Q       = 25736;  // round(pi * 8192)
  localparam int TWO_PI_Q   = 2 * PI_Q;

  // Block sum of 2^LOG2_N wrapped differences plus a sign bit; cannot overflow
  // while every difference stays inside (-PI_Q, PI_Q].
  localparam int ACC_W_DEF = WIDTH_DEF + LOG2_N_DEF + 1;
  typedef logic signed [ACC_W_DEF-1:0] acc_t;

  // EMPTY: no previous phase held, the next sample only primes the differencer.
  typedef enum logic {
    EMPTY = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/phase_freq_est_if.sv
// Purpose : phase-in / frequency-out stream bundle between atan2 and the demodulator.
// Latency : n/a (wires only).
// Backpres: none; the sink side has no ready, the source side is a one-cycle strobe.
// Ports   : sink_valid/sink_phase (upstream -> estimator),
//           source_valid/source_freq/source_wrap (estimator -> downstream).
interface phase_freq_est_if #(
  parameter int WIDTH = phase_freq_pkg::WIDTH_DEF
);

  logic                    sink_valid;
  logic signed [WIDTH-1:0] sink_phase;
  logic                    source_valid;
  logic signed [WIDTH-1:0] source_freq;
  logic                    source_wrap;

  // master: phase producer / frequency consumer; slave: the estimator itself
  modport master (
    output sink_valid,
    output sink_phase,
    input  source_valid,
    input  source_freq,
    input  source_wrap
  );

  modport slave (
    input  sink_valid,
    input  sink_phase,
    output source_valid,
    output source_freq,
    output source_wrap
  );

endinterface

// File: rtl/phase_freq_est_wrap_diff.sv
// Purpose : first-difference of consecutive phase samples, wrapped into (-PI_Q, PI_Q].
// Latency : 1 cycle from accepted sample to registered d_o/d_vld_o.
// Backpres: none; a sample is taken every cycle in_vld_i is high.
// Ports   : clk, rst_n; in_vld_i/in_phase_i sample input; have_prev_i says prev_q is real;
//           d_o (WIDTH+2 signed), d_vld_o strobe, wrapped_o set when a 2*pi correction applied.
module phase_wrap_diff #(
  parameter int WIDTH = phase_freq_pkg::WIDTH_DEF,
  parameter int PI_Q  = phase_freq_pkg::PI_Q
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_vld_i,
  input  logic signed [WIDTH-1:0] in_phase_i,
  input  logic                    have_prev_i,
  output logic signed [WIDTH+1:0] d_o,
  output logic                    d_vld_o,
  output logic                    wrapped_o
);

  localparam int DW = WIDTH + 2;
  typedef logic signed [DW-1:0] dw_t;

  localparam dw_t PI_S     = dw_t'(PI_Q);
  localparam dw_t TWO_PI_S = dw_t'(2 * PI_Q);

  logic signed [WIDTH-1:0] prev_q;
  dw_t                     raw;
  dw_t                     d_d,   d_q;
  logic                    wrap_d, wrap_q;
  logic                    vld_d,  vld_q;

  // Two guard bits keep the raw difference exact even for out-of-range input,
  // so nothing downstream sees an overflowed or undefined value.
  always_comb begin
    raw    = dw_t'(in_phase_i) - dw_t'(prev_q);
    d_d    = raw;
    wrap_d = 1'b0;
    if (raw > PI_S) begin
      d_d    = raw - TWO_PI_S;
      wrap_d = 1'b1;
    end else if (raw <= -PI_S) begin
      // Exactly -pi lands here and is reported as +pi.
      d_d    = raw + TWO_PI_S;
      wrap_d = 1'b1;
    end
    vld_d = in_vld_i & have_prev_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      d_q    <= '0;
      wrap_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= vld_d;
      if (in_vld_i) begin
        prev_q <= in_phase_i;
        // d/wrap only mean something when vld_d is set; loading them anyway
        // keeps the enable simple and they are never consumed otherwise.
        d_q    <= d_d;
        wrap_q <= wrap_d;
      end
    end
  end

  assign d_o       = d_q;
  assign d_vld_o   = vld_q;
  assign wrapped_o = wrap_q;

endmodule

// File: rtl/phase_freq_est.sv
// Purpose : block-averaged instantaneous frequency from a wrapped phase stream.
// Latency : 2 cycles from the sample that completes a block to source_valid.
// Backpres: none; accepts one sample per clock, gaps allowed, no stall.
// Ports   : clk, rst_n (async, active low); bus (slave modport): sink_valid/sink_phase in,
//           source_valid strobe, source_freq (rad/sample * 8192), source_wrap out.
module phase_freq_est #(
  parameter int WIDTH  = phase_freq_pkg::WIDTH_DEF,
  parameter int LOG2_N = phase_freq_pkg::LOG2_N_DEF,
  parameter int PI_Q   = phase_freq_pkg::PI_Q
) (
  input  logic              clk,
  input  logic              rst_n,
  phase_freq_est_if.slave   bus
);

  import phase_freq_pkg::*;

  localparam int ACC_W = WIDTH + LOG2_N + 1;
  localparam int DW    = WIDTH + 2;
  typedef logic signed [ACC_W-1:0] acc_w_t;

  // Half an LSB of the output, added before the arithmetic shift so that
  // ties round toward +infinity.
  localparam acc_w_t           RND  = acc_w_t'(1 << (LOG2_N - 1));
  localparam logic [LOG2_N-1:0] LAST = {LOG2_N{1'b1}};

  // ---------------------------------------------------------------- FSM
  state_e state_q, state_d;
  logic   have_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == EMPTY && bus.sink_valid) state_d = RUN;
  end

  always_comb begin
    have_prev = (state_q == RUN);
  end

  // ---------------------------------------------------------------- stage 1
  logic signed [DW-1:0] d;
  logic                 d_vld;
  logic                 d_wrapped;

  phase_wrap_diff #(
    .WIDTH (WIDTH),
    .PI_Q  (PI_Q)
  ) u_diff (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_vld_i    (bus.sink_valid),
    .in_phase_i  (bus.sink_phase),
    .have_prev_i (have_prev),
    .d_o         (d),
    .d_vld_o     (d_vld),
    .wrapped_o   (d_wrapped)
  );

  // ---------------------------------------------------------------- stage 2
  acc_w_t                  sum_q,  sum_d;
  acc_w_t                  d_ext;
  acc_w_t                  total;
  logic [LOG2_N-1:0]       cnt_q,  cnt_d;
  logic                    wacc_q, wacc_d;
  logic                    vld_q,  vld_d;
  logic signed [WIDTH-1:0] freq_q, freq_d;
  logic                    wrap_q, wrap_d;

  always_comb begin
    d_ext  = acc_w_t'(d);
    total  = sum_q + d_ext + RND;
    sum_d  = sum_q;
    cnt_d  = cnt_q;
    wacc_d = wacc_q;
    vld_d  = 1'b0;
    freq_d = freq_q;
    wrap_d = wrap_q;
    if (d_vld) begin
      if (cnt_q == LAST) begin
        // The N-th difference goes straight into the output word rather than
        // through sum_q, so the block closes without an extra cycle.
        freq_d = WIDTH'(total >>> LOG2_N);
        wrap_d = wacc_q | d_wrapped;
        vld_d  = 1'b1;
        sum_d  = '0;
        cnt_d  = '0;
        wacc_d = 1'b0;
      end else begin
        sum_d  = sum_q + d_ext;
        cnt_d  = cnt_q + 1'b1;
        wacc_d = wacc_q | d_wrapped;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cnt_q  <= '0;
      wacc_q <= 1'b0;
      vld_q  <= 1'b0;
      freq_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cnt_q  <= cnt_d;
      wacc_q <= wacc_d;
      vld_q  <= vld_d;
      freq_q <= freq_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.source_valid = vld_q;
  assign bus.source_freq  = freq_q;
  assign bus.source_wrap  = wrap_q;

endmodule

// File: tb/tb_phase_freq_est.sv
module tb_phase_freq_est;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  phase_freq_est_if #(.WIDTH(16)) bus ();

  phase_freq_est #(
    .WIDTH  (16),
    .LOG2_N (4),
    .PI_Q   (25736)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int edges       = 0;
  int last_edge   = 0;

  always @(posedge clk) edges <= edges + 1;

  // Every strobe is captured with the rising-edge index that produced it.
  logic [15:0] q_freq[$];
  logic        q_wrap[$];
  int          q_edge[$];

  always @(negedge clk) begin
    if (bus.source_valid === 1'b1) begin
      q_freq.push_back(bus.source_freq);
      q_wrap.push_back(bus.source_wrap);
      q_edge.push_back(edges);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int p);
    bus.sink_valid = 1'b1;
    bus.sink_phase = 16'(p);
    @(posedge clk);
    #1;
    last_edge      = edges;
    bus.sink_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    q_freq.delete();
    q_wrap.delete();
    q_edge.delete();
  endtask

  // exp_edge < 0 skips the latency comparison.
  task automatic pop_strobe(input string tag, input logic [15:0] ef, input logic ew,
                            input int exp_edge);
    chk({tag, "_present"}, 32'(q_freq.size() != 0), 32'd1);
    if (q_freq.size() != 0) begin
      chk({tag, "_freq"}, {16'h0, q_freq.pop_front()}, {16'h0, ef});
      chk({tag, "_wrap"}, {31'h0, q_wrap.pop_front()}, {31'h0, ew});
      if (exp_edge >= 0) chk({tag, "_latency"}, q_edge.pop_front(), exp_edge);
      else void'(q_edge.pop_front());
    end
  endtask

  function automatic int wrapv(input int v);
    if (v > 25736)  return v - 51472;
    if (v < -25736) return v + 51472;
    return v;
  endfunction

  initial begin
    bus.sink_valid = 1'b0;
    bus.sink_phase = '0;
    rst_n          = 1'b0;
    idle(2);

    // reset state
    chk("rst_valid", {31'h0, bus.source_valid}, 32'd0);
    chk("rst_freq",  {16'h0, bus.source_freq},  32'd0);
    chk("rst_wrap",  {31'h0, bus.source_wrap},  32'd0);
    rst_n = 1'b1;
    idle(1);

    // ramp +100, back-to-back, 17 samples -> one block
    for (int k = 0; k < 16; k++) send(k * 100);
    idle(2);
    chk("ramp_early", q_freq.size(), 0);
    send(1600);
    idle(3);
    chk("ramp_count", q_freq.size(), 1);
    pop_strobe("ramp", 16'd100, 1'b0, last_edge + 1);
    chk("ramp_pulse", {31'h0, bus.source_valid}, 32'd0);
    chk("ramp_hold",  {16'h0, bus.source_freq},  32'd100);

    // +1000 per sample across +pi: first block holds the crossing
    do_reset();
    for (int k = 0; k < 33; k++) send(wrapv(20000 + 1000 * k));
    idle(3);
    chk("wrap_count", q_freq.size(), 2);
    pop_strobe("wrap_b1", 16'd1000, 1'b1, -1);
    pop_strobe("wrap_b2", 16'd1000, 1'b0, -1);

    // -300 per sample across -pi
    do_reset();
    for (int k = 0; k < 17; k++) send(wrapv(-23000 - 300 * k));
    idle(3);
    chk("neg_count", q_freq.size(), 1);
    pop_strobe("neg", 16'hFED4, 1'b1, last_edge + 1);

    // rounding: block sums +8, -8, -9, and +9 plus an exact -pi step
    do_reset();
    send(0);
    for (int k = 0; k < 16; k++) send(8);
    send(0);
    for (int k = 0; k < 15; k++) send(0);
    for (int k = 0; k < 16; k++) send(-9);
    send(0);
    for (int k = 0; k < 15; k++) send(-25736);
    idle(3);
    chk("rnd_count", q_freq.size(), 4);
    pop_strobe("rnd_p8",  16'd1,    1'b0, -1);
    pop_strobe("rnd_m8",  16'd0,    1'b0, -1);
    pop_strobe("rnd_m9",  16'hFFFF, 1'b0, -1);
    pop_strobe("rnd_mpi", 16'd1609, 1'b1, -1);

    // gapped ramp, one valid in three cycles
    do_reset();
    for (int k = 0; k < 16; k++) begin
      send(k * 100);
      idle(2);
    end
    chk("gap_early", q_freq.size(), 0);
    send(1600);
    idle(3);
    chk("gap_count", q_freq.size(), 1);
    pop_strobe("gap", 16'd100, 1'b0, last_edge + 1);

    // reset part-way through a block, then a clean +50 block
    for (int k = 0; k < 10; k++) send(2000 + 777 * k);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'h0, bus.source_valid}, 32'd0);
    chk("mid_rst_freq",  {16'h0, bus.source_freq},  32'd0);
    chk("mid_rst_wrap",  {31'h0, bus.source_wrap},  32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    q_freq.delete();
    q_wrap.delete();
    q_edge.delete();
    for (int k = 0; k < 17; k++) send(5000 + 50 * k);
    idle(3);
    chk("mid_count", q_freq.size(), 1);
    pop_strobe("mid", 16'd50, 1'b0, last_edge + 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
